// File: rtl/axi_lite_slave_regs.sv
// axi_lite_slave_regs: AXI4-Lite responder exposing NUM_REGS word registers in parallel,
// with a one-cycle write pulse per committed register.
module axi_lite_slave_regs #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int NUM_REGS       = 16
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                         S_AXI_AWPROT,
    input  logic                               S_AXI_AWVALID,
    output logic                               S_AXI_AWREADY,
    input  logic [AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                               S_AXI_WVALID,
    output logic                               S_AXI_WREADY,
    output logic [1:0]                         S_AXI_BRESP,
    output logic                               S_AXI_BVALID,
    input  logic                               S_AXI_BREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                         S_AXI_ARPROT,
    input  logic                               S_AXI_ARVALID,
    output logic                               S_AXI_ARREADY,
    output logic [AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                         S_AXI_RRESP,
    output logic                               S_AXI_RVALID,
    input  logic                               S_AXI_RREADY,
    output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]                wr_pulse_o
);
    localparam int NB  = AXI_DATA_WIDTH / 8;
    localparam int OFF = $clog2(NB);
    localparam int IW  = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic [AXI_DATA_WIDTH-1:0] regs [NUM_REGS];
    logic aw_ready, w_ready, ar_ready, aw_got, w_got;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr, wa, wi, ri;
    logic [AXI_DATA_WIDTH-1:0] w_data, wd;
    logic [NB-1:0] w_strb, ws;
    logic aw_hs, w_hs, ar_hs, commit, w_ok, r_ok;
    logic [IW-1:0] w_idx, r_idx;
    logic unused_prot;

    assign unused_prot   = ^{S_AXI_AWPROT, S_AXI_ARPROT};
    assign S_AXI_AWREADY = aw_ready;
    assign S_AXI_WREADY  = w_ready;
    assign S_AXI_ARREADY = ar_ready;
    assign S_AXI_BVALID  = w_state == W_RESP;
    assign S_AXI_RVALID  = r_state == R_RESP;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign regs_o[g*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = regs[g];
    end

    // Current-cycle handshakes bypass the latches so a same-cycle AW+W commits at once.
    always_comb begin
        aw_hs  = S_AXI_AWVALID & aw_ready;
        w_hs   = S_AXI_WVALID & w_ready;
        ar_hs  = S_AXI_ARVALID & ar_ready;
        wa     = aw_hs ? S_AXI_AWADDR : aw_addr;
        wd     = w_hs ? S_AXI_WDATA : w_data;
        ws     = w_hs ? S_AXI_WSTRB : w_strb;
        wi     = wa >> OFF;
        ri     = S_AXI_ARADDR >> OFF;
        w_ok   = wi < AXI_ADDR_WIDTH'(NUM_REGS);
        r_ok   = ri < AXI_ADDR_WIDTH'(NUM_REGS);
        w_idx  = IW'(wi);
        r_idx  = IW'(ri);
        commit = (w_state == W_IDLE) & (aw_got | aw_hs) & (w_got | w_hs);
        w_next = w_state == W_IDLE ? (commit ? W_RESP : W_IDLE) : (S_AXI_BREADY ? W_IDLE : W_RESP);
        r_next = r_state == R_IDLE ? (ar_hs ? R_RESP : R_IDLE) : (S_AXI_RREADY ? R_IDLE : R_RESP);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_state     <= W_IDLE;
            r_state     <= R_IDLE;
            aw_ready    <= 1'b0;
            w_ready     <= 1'b0;
            ar_ready    <= 1'b0;
            aw_got      <= 1'b0;
            w_got       <= 1'b0;
            aw_addr     <= '0;
            w_data      <= '0;
            w_strb      <= '0;
            S_AXI_BRESP <= 2'b00;
            S_AXI_RRESP <= 2'b00;
            S_AXI_RDATA <= '0;
            wr_pulse_o  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            w_state    <= w_next;
            r_state    <= r_next;
            aw_got     <= (w_next == W_IDLE) & (aw_got | aw_hs);
            w_got      <= (w_next == W_IDLE) & (w_got | w_hs);
            aw_ready   <= (w_next == W_IDLE) & ~(aw_got | aw_hs);
            w_ready    <= (w_next == W_IDLE) & ~(w_got | w_hs);
            ar_ready   <= r_next == R_IDLE;
            wr_pulse_o <= (commit & w_ok) ? NUM_REGS'(1) << w_idx : '0;
            if (aw_hs) aw_addr <= S_AXI_AWADDR;
            if (w_hs) begin
                w_data <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
            end
            if (commit) S_AXI_BRESP <= w_ok ? 2'b00 : 2'b10;
            if (ar_hs) begin
                S_AXI_RDATA <= r_ok ? regs[r_idx] : '0;
                S_AXI_RRESP <= r_ok ? 2'b00 : 2'b10;
            end
            for (int i = 0; i < NUM_REGS; i++)
                for (int b = 0; b < NB; b++)
                    if (commit && w_ok && w_idx == IW'(i) && ws[b]) regs[i][b*8 +: 8] <= wd[b*8 +: 8];
        end
    end
endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// tb_axi_lite_slave_regs: directed and random AXI-Lite traffic against a register-array model.
module tb_axi_lite_slave_regs;
    localparam int DW = 32, AW = 32, N = 16;

    logic aclk = 1'b0, aresetn = 1'b0;
    logic [AW-1:0] S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
    logic [2:0] S_AXI_AWPROT = '0, S_AXI_ARPROT = '0;
    logic S_AXI_AWVALID = 0, S_AXI_WVALID = 0, S_AXI_BREADY = 0, S_AXI_ARVALID = 0, S_AXI_RREADY = 0;
    logic [DW-1:0] S_AXI_WDATA = '0;
    logic [DW/8-1:0] S_AXI_WSTRB = '0;
    logic S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
    logic [1:0] S_AXI_BRESP, S_AXI_RRESP;
    logic [DW-1:0] S_AXI_RDATA;
    logic [N*DW-1:0] regs_o;
    logic [N-1:0] wr_pulse_o;

    logic [31:0] model [N];
    int n_cmp = 0, n_err = 0;

    always #5 aclk = ~aclk;

    axi_lite_slave_regs #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .NUM_REGS(N)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP),
        .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR),
        .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
        .S_AXI_RREADY(S_AXI_RREADY), .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
    );

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] flat();
        logic [511:0] f = '0;
        for (int i = 0; i < N; i++) f[i*32 +: 32] = model[i];
        return f;
    endfunction

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_d, input int w_d, input int b_d);
        bit aw_done = 0, w_done = 0, aw_f, w_f, ok;
        int cyc = 0, idx;
        idx = int'(a >> 2);
        ok  = (a >> 2) < 32'(N);
        while (!(aw_done && w_done) && cyc < 40) begin
            S_AXI_AWVALID = !aw_done && cyc >= aw_d;
            S_AXI_AWADDR  = a;
            S_AXI_WVALID  = !w_done && cyc >= w_d;
            S_AXI_WDATA   = d;
            S_AXI_WSTRB   = s;
            aw_f = S_AXI_AWVALID && S_AXI_AWREADY;
            w_f  = S_AXI_WVALID && S_AXI_WREADY;
            step();
            cyc++;
            aw_done |= aw_f;
            w_done  |= w_f;
            if (aw_done && !w_done) chk("awready_drop", S_AXI_AWREADY, 0);
            if (w_done && !aw_done) chk("wready_drop", S_AXI_WREADY, 0);
        end
        S_AXI_AWVALID = 0;
        S_AXI_WVALID  = 0;
        chk("wr_handshakes", aw_done && w_done, 1);
        chk("b_latency", cyc, (aw_d > w_d ? aw_d : w_d) + 1);
        if (ok) for (int b = 0; b < 4; b++) if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
        chk("bvalid", S_AXI_BVALID, 1);
        chk("bresp", S_AXI_BRESP, ok ? 2'b00 : 2'b10);
        chk("wr_pulse", wr_pulse_o, ok ? 16'(1) << idx : 16'h0);
        chk("regs_after_write", regs_o, flat());
        repeat (b_d) begin
            step();
            chk("bvalid_hold", S_AXI_BVALID, 1);
            chk("bresp_hold", S_AXI_BRESP, ok ? 2'b00 : 2'b10);
            chk("wready_low", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b00);
            chk("pulse_once", wr_pulse_o, 0);
        end
        S_AXI_BREADY = 1;
        step();
        S_AXI_BREADY = 0;
        chk("bvalid_clear", S_AXI_BVALID, 0);
        chk("wready_back", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
        chk("pulse_off", wr_pulse_o, 0);
    endtask

    task automatic axi_read(input logic [31:0] a, input int r_d);
        bit ok;
        int cyc = 0;
        logic [31:0] exp_d;
        ok    = (a >> 2) < 32'(N);
        exp_d = ok ? model[int'(a >> 2)] : 32'h0;
        S_AXI_ARVALID = 1;
        S_AXI_ARADDR  = a;
        while (!S_AXI_ARREADY && cyc < 20) begin
            step();
            cyc++;
        end
        chk("arready_wait", S_AXI_ARREADY, 1);
        step();
        S_AXI_ARVALID = 0;
        chk("rvalid", S_AXI_RVALID, 1);
        chk("rdata", S_AXI_RDATA, exp_d);
        chk("rresp", S_AXI_RRESP, ok ? 2'b00 : 2'b10);
        chk("arready_low", S_AXI_ARREADY, 0);
        repeat (r_d) begin
            step();
            chk("rvalid_hold", S_AXI_RVALID, 1);
            chk("rdata_hold", S_AXI_RDATA, exp_d);
        end
        S_AXI_RREADY = 1;
        step();
        S_AXI_RREADY = 0;
        chk("rvalid_clear", S_AXI_RVALID, 0);
        chk("arready_back", S_AXI_ARREADY, 1);
    endtask

    initial begin
        logic [31:0] a, d;
        for (int i = 0; i < N; i++) model[i] = '0;
        repeat (3) step();
        chk("reset_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
        chk("reset_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
        chk("reset_regs", regs_o, flat());
        chk("reset_misc", {wr_pulse_o, S_AXI_RDATA, S_AXI_BRESP, S_AXI_RRESP}, 0);
        aresetn = 1;
        step();
        chk("release_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

        axi_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        chk("reg2_value", regs_o[2*32 +: 32], 32'hDEADBEEF);
        axi_write(32'h04, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        axi_write(32'h04, 32'h12345678, 4'h3, 0, 3, 0);
        chk("reg1_partial", regs_o[1*32 +: 32], 32'hFFFF5678);
        axi_write(32'h08, 32'h0BADF00D, 4'h0, 2, 0, 1);
        axi_write(32'h40, 32'hAAAA5555, 4'hF, 0, 0, 0);
        axi_read(32'h40, 0);
        axi_write(32'h10, 32'hCAFEF00D, 4'hF, 1, 0, 5);
        axi_read(32'h08, 2);

        axi_write(32'h0C, 32'h1, 4'hF, 0, 0, 0);
        S_AXI_AWVALID = 1; S_AXI_AWADDR = 32'h0C; S_AXI_WVALID = 1; S_AXI_WDATA = 32'h2; S_AXI_WSTRB = 4'hF;
        S_AXI_ARVALID = 1; S_AXI_ARADDR = 32'h0C;
        step();
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
        model[3] = 32'h2;
        chk("same_cycle_rdata", S_AXI_RDATA, 32'h1);
        chk("same_cycle_valids", {S_AXI_RVALID, S_AXI_BVALID}, 2'b11);
        chk("same_cycle_reg3", regs_o[3*32 +: 32], 32'h2);
        S_AXI_BREADY = 1; S_AXI_RREADY = 1;
        step();
        S_AXI_BREADY = 0; S_AXI_RREADY = 0;
        axi_read(32'h0C, 0);

        S_AXI_AWVALID = 1; S_AXI_AWADDR = 32'h14; S_AXI_WVALID = 1; S_AXI_WDATA = 32'h55AA55AA; S_AXI_WSTRB = 4'hF;
        step();
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        chk("pre_reset_bvalid", S_AXI_BVALID, 1);
        aresetn = 0;
        step();
        for (int i = 0; i < N; i++) model[i] = '0;
        chk("midreset_bvalid", S_AXI_BVALID, 0);
        chk("midreset_regs", regs_o, flat());
        chk("midreset_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
        chk("midreset_pulse", wr_pulse_o, 0);
        aresetn = 1;
        step();
        chk("postreset_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        chk("postreset_bvalid", S_AXI_BVALID, 0);
        axi_read(32'h14, 0);

        for (int k = 0; k < 60; k++) begin
            a = ($urandom_range(0, 19) << 2) | $urandom_range(0, 3);
            d = $urandom;
            if ($urandom_range(0, 2) != 0)
                axi_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            else
                axi_read(a, $urandom_range(0, 3));
        end
        chk("final_regs", regs_o, flat());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
